sramlike_axi_bridge: RTL and testbench

Converts the core's two sram-like master ports (instruction fetch, data access) into a single AXI master for the memory system. It sits directly downstream of `mycpu_top`, consuming its request/addr_ok/data_ok traffic. It arbitrates the two read sources onto AR/R and the data write source onto AW/W/B. It keeps one read and one write in flight and enforces read/write ordering for data accesses.

---
 rtl/sramlike_axi_bridge_if.sv | 97 +++++++++
 rtl/sramlike_axi_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sramlike_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : sramlike_axi_bridge_if
// Description : Bundles the two sram-like core ports and the AXI master
//               channels seen by sramlike_axi_bridge. The master modport is
//               the bridge's view; the slave modport is the environment's
//               view (core plus memory system).
// Revision    : 1.0 - initial release
// ============================================================================
interface sramlike_axi_bridge_if;

  // instruction-side sram-like port
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  // data-side sram-like port
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  // AXI read address / read data
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  // AXI write address / write data / write response
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output arid, araddr, arsize, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awaddr, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  arid, araddr, arsize, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

`default_nettype wire

// File: rtl/sramlike_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sramlike_axi_bridge
// Description : Converts the core's instruction and data sram-like ports into
//               one AXI master. One read (AR/R) and one write (AW/W/B) may be
//               in flight; data reads and data writes are kept in order.
// Revision    : 1.0 - initial release
// ============================================================================
module sramlike_axi_bridge (
  input wire                    clk,
  input wire                    resetn,
  sramlike_axi_bridge_if.master bus
);

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wr_state_e;

  // read channel state
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_size_q, ar_size_d;
  logic [3:0]  ar_id_q, ar_id_d;

  // write channel state
  wr_state_e   wr_state_q, wr_state_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [1:0]  aw_size_q, aw_size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // request decode and completion events
  logic data_rd_req;
  logic data_wr_req;
  logic data_rd_inflight;
  logic data_rd_accept;
  logic inst_rd_accept;
  logic data_wr_accept;
  logic rd_done_inst;
  logic rd_done_data;
  logic wr_done;

  // The inst side never writes, so its write-only fields are not consumed.
  logic unused_inst_wr_fields;
  assign unused_inst_wr_fields = ^{bus.inst_sram_wr, bus.inst_sram_wstrb,
                                   bus.inst_sram_wdata};

  // Acceptance and completion decode shared by both FSMs and the outputs.
  always_comb begin
    data_rd_req      = bus.data_sram_req && !bus.data_sram_wr;
    data_wr_req      = bus.data_sram_req && bus.data_sram_wr;
    // A data read holding the read channel blocks later data writes.
    data_rd_inflight = (rd_state_q != R_IDLE) && (ar_id_q == ID_DATA);
    // Data reads wait for the write channel to drain so loads see prior stores.
    data_rd_accept   = (rd_state_q == R_IDLE) && data_rd_req && (wr_state_q == W_IDLE);
    // Inst fetch takes the read channel whenever no data read is taking it.
    inst_rd_accept   = (rd_state_q == R_IDLE) && bus.inst_sram_req && !data_rd_accept;
    data_wr_accept   = (wr_state_q == W_IDLE) && data_wr_req && !data_rd_inflight;
    rd_done_inst     = (rd_state_q == R_R) && bus.rvalid && (bus.rid == ID_INST);
    rd_done_data     = (rd_state_q == R_R) && bus.rvalid && (bus.rid == ID_DATA);
    wr_done          = (wr_state_q == W_B) && bus.bvalid;
  end

  // sram-like handshake outputs; read data passes straight through.
  assign bus.inst_sram_addr_ok = inst_rd_accept;
  assign bus.data_sram_addr_ok = data_rd_accept || data_wr_accept;
  assign bus.inst_sram_data_ok = rd_done_inst;
  // Ordering rules keep read and write completions on the data side disjoint.
  assign bus.data_sram_data_ok = rd_done_data || wr_done;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.data_sram_rdata   = bus.rdata;

  // AXI master outputs, all taken from registered state.
  assign bus.arid    = ar_id_q;
  assign bus.araddr  = ar_addr_q;
  assign bus.arsize  = {1'b0, ar_size_q};
  assign bus.arvalid = (rd_state_q == R_AR);
  assign bus.rready  = (rd_state_q == R_R);
  assign bus.awaddr  = aw_addr_q;
  assign bus.awsize  = {1'b0, aw_size_q};
  assign bus.awvalid = (wr_state_q == W_REQ) && !aw_done_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = (wr_state_q == W_REQ) && !w_done_q;
  assign bus.bready  = (wr_state_q == W_B);

  // Read FSM next state: capture the winning request, then AR, then R.
  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    ar_id_d    = ar_id_q;
    case (rd_state_q)
      R_IDLE: begin
        if (data_rd_accept) begin
          ar_addr_d  = bus.data_sram_addr;
          ar_size_d  = bus.data_sram_size;
          ar_id_d    = ID_DATA;
          rd_state_d = R_AR;
        end else if (inst_rd_accept) begin
          ar_addr_d  = bus.inst_sram_addr;
          ar_size_d  = bus.inst_sram_size;
          ar_id_d    = ID_INST;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        if (bus.arready) begin
          rd_state_d = R_R;
        end
      end
      R_R: begin
        if (bus.rvalid) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: AW and W complete independently before B.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_addr_d  = aw_addr_q;
    aw_size_d  = aw_size_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (wr_state_q)
      W_IDLE: begin
        if (data_wr_accept) begin
          aw_addr_d  = bus.data_sram_addr;
          aw_size_d  = bus.data_sram_size;
          wstrb_d    = bus.data_sram_wstrb;
          wdata_d    = bus.data_sram_wdata;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        if (!aw_done_q && bus.awready) begin
          aw_done_d = 1'b1;
        end
        if (!w_done_q && bus.wready) begin
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_B;
        end
      end
      W_B: begin
        if (bus.bvalid) begin
          wr_state_d = W_IDLE;
        end
      end
      default: begin
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= 32'd0;
      ar_size_q  <= 2'd0;
      ar_id_q    <= 4'd0;
      wr_state_q <= W_IDLE;
      aw_addr_q  <= 32'd0;
      aw_size_q  <= 2'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      ar_id_q    <= ar_id_d;
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_size_q  <= aw_size_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sramlike_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sramlike_axi_bridge
// Description : Self-checking bench for sramlike_axi_bridge. The bench plays
//               both the core and the AXI memory; expected completions are
//               queued when responses are driven and checked on data_ok.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sramlike_axi_bridge;

  logic clk;
  logic resetn;

  sramlike_axi_bridge_if bus ();

  sramlike_axi_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // expected inst read data; data entries are {is_write, rdata}
  logic [31:0] inst_q [$];
  logic [32:0] data_q [$];
  logic [31:0] mon_inst;
  logic [32:0] mon_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every data_ok must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.inst_sram_data_ok === 1'b1) begin
      checks++;
      if (inst_q.size() == 0) begin
        errors++; $display("FAIL inst_sb: got unexpected inst data_ok, want none");
      end else begin
        mon_inst = inst_q.pop_front();
        if (bus.inst_sram_rdata !== mon_inst) begin
          errors++; $display("FAIL inst_sb rdata: got %h want %h", bus.inst_sram_rdata, mon_inst);
        end
      end
    end
    if (bus.data_sram_data_ok === 1'b1) begin
      checks++;
      if (data_q.size() == 0) begin
        errors++; $display("FAIL data_sb: got unexpected data data_ok, want none");
      end else begin
        mon_data = data_q.pop_front();
        if (!mon_data[32] && (bus.data_sram_rdata !== mon_data[31:0])) begin
          errors++; $display("FAIL data_sb rdata: got %h want %h", bus.data_sram_rdata, mon_data[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.inst_sram_req   = 1'b0; bus.inst_sram_wr   = 1'b0; bus.inst_sram_size = 2'd0;
    bus.inst_sram_wstrb = 4'd0; bus.inst_sram_addr = 32'd0; bus.inst_sram_wdata = 32'd0;
    bus.data_sram_req   = 1'b0; bus.data_sram_wr   = 1'b0; bus.data_sram_size = 2'd0;
    bus.data_sram_wstrb = 4'd0; bus.data_sram_addr = 32'd0; bus.data_sram_wdata = 32'd0;
    bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
  endtask

  task automatic inst_req(input logic [31:0] addr);
    bus.inst_sram_req = 1'b1; bus.inst_sram_size = 2'd2; bus.inst_sram_addr = addr;
  endtask

  task automatic data_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd);
    bus.data_sram_req = 1'b1; bus.data_sram_wr = wr; bus.data_sram_size = size;
    bus.data_sram_addr = addr; bus.data_sram_wstrb = strb; bus.data_sram_wdata = wd;
  endtask

  task automatic read_resp(input logic [3:0] id, input logic [31:0] d);
    bus.rvalid = 1'b1; bus.rid = id; bus.rdata = d;
    if (id == 4'd0) inst_q.push_back(d);
    else            data_q.push_back({1'b0, d});
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    step(); step(); mid();
    checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
      errors++; $display("FAIL reset valids: got %b want 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
    checks++; if ({bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok, bus.data_sram_data_ok} !== 4'b0) begin
      errors++; $display("FAIL reset oks: got %b want 0000", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok, bus.inst_sram_data_ok, bus.data_sram_data_ok}); end
    checks++; if ({bus.araddr, bus.awaddr, bus.wdata, bus.wstrb} !== 100'd0) begin
      errors++; $display("FAIL reset regs: got %h want 0", {bus.araddr, bus.awaddr, bus.wdata, bus.wstrb}); end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_inst_read();
    inst_req(32'hBFC0_0000);
    mid();
    checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL inst_rd addr_ok: got %b want 1", bus.inst_sram_addr_ok); end
    step(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    checks++; if ({bus.arvalid, bus.arid} !== {1'b1, 4'd0}) begin errors++; $display("FAIL inst_rd ar: got %b/%h want 1/0", bus.arvalid, bus.arid); end
    checks++; if ({bus.araddr, bus.arsize} !== {32'hBFC0_0000, 3'd2}) begin errors++; $display("FAIL inst_rd araddr: got %h/%h want bfc00000/2", bus.araddr, bus.arsize); end
    step(); bus.arready = 1'b0; read_resp(4'd0, 32'h3C1D_0000);
    mid();
    checks++; if ({bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.rready} !== 3'b101) begin
      errors++; $display("FAIL inst_rd data_ok: got %b want 101", {bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.rready}); end
    step(); bus.rvalid = 1'b0;
    mid();
    checks++; if ({bus.arvalid, bus.rready, bus.inst_sram_data_ok} !== 3'b0) begin
      errors++; $display("FAIL inst_rd idle: got %b want 000", {bus.arvalid, bus.rready, bus.inst_sram_data_ok}); end
    step();
  endtask

  task automatic test_simultaneous_read();
    inst_req(32'hBFC0_0004);
    data_req(1'b0, 2'd2, 32'h8000_0010, 4'd0, 32'd0);
    mid();
    checks++; if ({bus.data_sram_addr_ok, bus.inst_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL simul addr_ok: got %b want 10", {bus.data_sram_addr_ok, bus.inst_sram_addr_ok}); end
    step(); bus.data_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    checks++; if ({bus.arid, bus.araddr} !== {4'd1, 32'h8000_0010}) begin errors++; $display("FAIL simul data ar: got %h/%h want 1/80000010", bus.arid, bus.araddr); end
    checks++; if (bus.inst_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL simul inst blocked: got %b want 0", bus.inst_sram_addr_ok); end
    step(); bus.arready = 1'b0; read_resp(4'd1, 32'hDEAD_BEEF);
    mid();
    checks++; if ({bus.data_sram_data_ok, bus.inst_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL simul data_ok: got %b want 10", {bus.data_sram_data_ok, bus.inst_sram_addr_ok}); end
    step(); bus.rvalid = 1'b0;
    mid();
    checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL simul inst accept: got %b want 1", bus.inst_sram_addr_ok); end
    step(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    checks++; if ({bus.arid, bus.araddr} !== {4'd0, 32'hBFC0_0004}) begin errors++; $display("FAIL simul inst ar: got %h/%h want 0/bfc00004", bus.arid, bus.araddr); end
    step(); bus.arready = 1'b0; read_resp(4'd0, 32'h1111_2222);
    mid();
    checks++; if (bus.inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL simul inst data_ok: got %b want 1", bus.inst_sram_data_ok); end
    step(); drive_idle(); step();
  endtask

  task automatic test_store_split();
    data_req(1'b1, 2'd1, 32'h8000_1000, 4'h3, 32'h0000_1234);
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL store addr_ok: got %b want 1", bus.data_sram_addr_ok); end
    step(); bus.data_sram_req = 1'b0; bus.awready = 1'b1;
    mid();
    checks++; if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b110) begin errors++; $display("FAIL store c1 valids: got %b want 110", {bus.awvalid, bus.wvalid, bus.bready}); end
    checks++; if ({bus.awaddr, bus.awsize, bus.wstrb, bus.wdata} !== {32'h8000_1000, 3'd1, 4'h3, 32'h0000_1234}) begin
      errors++; $display("FAIL store payload: got %h/%h/%h/%h want 80001000/1/3/00001234", bus.awaddr, bus.awsize, bus.wstrb, bus.wdata); end
    step(); bus.awready = 1'b0;
    mid();
    checks++; if ({bus.awvalid, bus.wvalid} !== 2'b01) begin errors++; $display("FAIL store c2 valids: got %b want 01", {bus.awvalid, bus.wvalid}); end
    step(); bus.wready = 1'b1;
    mid();
    checks++; if ({bus.wvalid, bus.bready} !== 2'b10) begin errors++; $display("FAIL store c3: got %b want 10", {bus.wvalid, bus.bready}); end
    step(); bus.wready = 1'b0;
    mid();
    checks++; if ({bus.wvalid, bus.bready, bus.data_sram_data_ok} !== 3'b010) begin
      errors++; $display("FAIL store c4: got %b want 010", {bus.wvalid, bus.bready, bus.data_sram_data_ok}); end
    step(); bus.bvalid = 1'b1; data_q.push_back({1'b1, 32'd0});
    mid();
    checks++; if (bus.data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL store data_ok: got %b want 1", bus.data_sram_data_ok); end
    step(); bus.bvalid = 1'b0;
    mid();
    checks++; if (bus.bready !== 1'b0) begin errors++; $display("FAIL store bready after: got %b want 0", bus.bready); end
    step();
  endtask

  task automatic test_load_after_store();
    data_req(1'b1, 2'd2, 32'h8000_2000, 4'hF, 32'h5555_AAAA);
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL las store addr_ok: got %b want 1", bus.data_sram_addr_ok); end
    step(); data_req(1'b0, 2'd2, 32'h8000_2004, 4'd0, 32'd0); bus.awready = 1'b1; bus.wready = 1'b1;
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL las load held c1: got %b want 0", bus.data_sram_addr_ok); end
    step(); bus.awready = 1'b0; bus.wready = 1'b0;
    mid();
    checks++; if ({bus.data_sram_addr_ok, bus.bready} !== 2'b01) begin errors++; $display("FAIL las load held c2: got %b want 01", {bus.data_sram_addr_ok, bus.bready}); end
    step(); bus.bvalid = 1'b1; data_q.push_back({1'b1, 32'd0});
    mid();
    checks++; if ({bus.data_sram_data_ok, bus.data_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL las write done: got %b want 10", {bus.data_sram_data_ok, bus.data_sram_addr_ok}); end
    step(); bus.bvalid = 1'b0;
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL las load accept: got %b want 1", bus.data_sram_addr_ok); end
    step(); bus.data_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    checks++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h8000_2004}) begin
      errors++; $display("FAIL las ar: got %b/%h/%h want 1/1/80002004", bus.arvalid, bus.arid, bus.araddr); end
    step(); bus.arready = 1'b0; read_resp(4'd1, 32'hCAFE_F00D);
    mid();
    step(); drive_idle(); step();
  endtask

  task automatic test_back_pressure();
    data_req(1'b0, 2'd0, 32'h8000_0003, 4'd0, 32'd0);
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL bp addr_ok: got %b want 1", bus.data_sram_addr_ok); end
    step(); data_req(1'b1, 2'd2, 32'h8000_3000, 4'hF, 32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      mid();
      checks++; if ({bus.arvalid, bus.araddr, bus.arsize} !== {1'b1, 32'h8000_0003, 3'd0}) begin
        errors++; $display("FAIL bp hold %0d: got %b/%h/%h want 1/80000003/0", i, bus.arvalid, bus.araddr, bus.arsize); end
      checks++; if (bus.data_sram_addr_ok !== 1'b0) begin errors++; $display("FAIL bp store blocked %0d: got %b want 0", i, bus.data_sram_addr_ok); end
      step();
    end
    bus.arready = 1'b1;
    mid();
    step(); bus.arready = 1'b0; read_resp(4'd1, 32'h0000_00AB);
    mid();
    checks++; if ({bus.data_sram_data_ok, bus.data_sram_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL bp read done: got %b want 10", {bus.data_sram_data_ok, bus.data_sram_addr_ok}); end
    step(); bus.rvalid = 1'b0;
    mid();
    checks++; if (bus.data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL bp store accept: got %b want 1", bus.data_sram_addr_ok); end
    step(); bus.data_sram_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    mid();
    checks++; if ({bus.awvalid, bus.wvalid, bus.wdata} !== {2'b11, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL bp store aw/w: got %b%b/%h want 11/a5a5a5a5", bus.awvalid, bus.wvalid, bus.wdata); end
    step(); bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1; data_q.push_back({1'b1, 32'd0});
    mid();
    step(); drive_idle(); step();
  endtask

  task automatic test_concurrent();
    inst_req(32'hBFC0_0200);
    data_req(1'b1, 2'd2, 32'h8000_4000, 4'hF, 32'h0BAD_F00D);
    mid();
    checks++; if ({bus.inst_sram_addr_ok, bus.data_sram_addr_ok} !== 2'b11) begin
      errors++; $display("FAIL conc addr_ok: got %b want 11", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok}); end
    step(); bus.inst_sram_req = 1'b0; bus.data_sram_req = 1'b0;
    bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    mid();
    checks++; if ({bus.arvalid, bus.awvalid, bus.wvalid} !== 3'b111) begin
      errors++; $display("FAIL conc valids: got %b want 111", {bus.arvalid, bus.awvalid, bus.wvalid}); end
    step(); bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    read_resp(4'd0, 32'h2408_0001); bus.bvalid = 1'b1; data_q.push_back({1'b1, 32'd0});
    mid();
    checks++; if ({bus.inst_sram_data_ok, bus.data_sram_data_ok} !== 2'b11) begin
      errors++; $display("FAIL conc data_ok: got %b want 11", {bus.inst_sram_data_ok, bus.data_sram_data_ok}); end
    step(); drive_idle(); step();
  endtask

  task automatic test_reset_mid_read();
    inst_req(32'hBFC0_0300);
    mid();
    step(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    step(); bus.arready = 1'b0;
    mid();
    checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL rst_rd in R_R: got rready %b want 1", bus.rready); end
    #1; resetn = 1'b0; bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h1234_5678;
    #1;
    checks++; if ({bus.arvalid, bus.rready, bus.inst_sram_data_ok, bus.data_sram_data_ok} !== 4'b0) begin
      errors++; $display("FAIL rst_rd immediate: got %b want 0000", {bus.arvalid, bus.rready, bus.inst_sram_data_ok, bus.data_sram_data_ok}); end
    step(); resetn = 1'b1; drive_idle();
    step();
    inst_req(32'hBFC0_0008);
    mid();
    checks++; if (bus.inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL rst_rd reissue addr_ok: got %b want 1", bus.inst_sram_addr_ok); end
    step(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
    mid();
    checks++; if ({bus.arvalid, bus.araddr} !== {1'b1, 32'hBFC0_0008}) begin errors++; $display("FAIL rst_rd reissue ar: got %b/%h want 1/bfc00008", bus.arvalid, bus.araddr); end
    step(); bus.arready = 1'b0; read_resp(4'd0, 32'h0000_0021);
    mid();
    checks++; if (bus.inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL rst_rd reissue data_ok: got %b want 1", bus.inst_sram_data_ok); end
    step(); drive_idle(); step();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_simultaneous_read();
    test_store_split();
    test_load_after_store();
    test_back_pressure();
    test_concurrent();
    test_reset_mid_read();
    step(); step();
    checks++; if ((inst_q.size() + data_q.size()) != 0) begin
      errors++; $display("FAIL scoreboard drain: got %0d pending want 0", inst_q.size() + data_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
